// File: rtl/bound_flasher_if.sv
// Lamp sequencer pin bundle: flick request in, 16 registered lamp drives out.
interface bound_flasher_if;
    logic        flick;
    logic [15:0] LEDs;

    modport master (output flick, input LEDs);
    modport slave  (input flick, output LEDs);
endinterface

// File: rtl/bound_flasher.sv
// 16-lamp bound flasher: fixed ON/OFF sweep with flick kickback at L5/L10.
// Optional macro FLICK_LATCH_EN: flick goes through a sticky async-set request flop.
module bound_flasher (
    input  logic            clk,
    input  logic            rst,
    bound_flasher_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6} state_t;

    state_t      state, state_nxt;
    logic [15:0] leds, leds_nxt;
    logic [15:0] on_step, off_step;
    logic        f;

`ifdef FLICK_LATCH_EN
    logic req;

    // Set as soon as flick rises; a clock edge with flick low clears it, so a
    // pulse between edges is still seen by the FSM at the next edge.
    always_ff @(posedge clk or posedge rst or posedge bus.flick) begin
        if (rst)            req <= 1'b0;
        else if (bus.flick) req <= 1'b1;
        else                req <= 1'b0;
    end

    assign f = req;
`else
    assign f = bus.flick;
`endif

    assign on_step  = {leds[14:0], 1'b1};
    assign off_step = {1'b0, leds[15:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            leds  <= 16'h0000;
        end else begin
            state <= state_nxt;
            leds  <= leds_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        leds_nxt  = leds;
        case (state)
            IDLE: begin
                leds_nxt = 16'h0000;
                if (f) begin
                    state_nxt = S1;
                    leds_nxt  = 16'h0001;
                end
            end
            S1: begin
                if (leds == 16'h003F) begin
                    state_nxt = S2;
                    leds_nxt  = off_step;
                end else leds_nxt = on_step;
            end
            S2: begin
                if (leds == 16'h0000) begin
                    state_nxt = S3;
                    leds_nxt  = on_step;
                end else leds_nxt = off_step;
            end
            S3: begin
                // L10 top always turns back; flick there picks the deep fall to L0
                if ((leds == 16'h003F && f) || leds == 16'h07FF) begin
                    state_nxt = (leds == 16'h07FF && !f) ? S4 : S2;
                    leds_nxt  = off_step;
                end else leds_nxt = on_step;
            end
            S4: begin
                if (leds == 16'h001F) begin
                    state_nxt = S5;
                    leds_nxt  = on_step;
                end else leds_nxt = off_step;
            end
            S5: begin
                if (f && (leds == 16'h003F || leds == 16'h07FF)) begin
                    state_nxt = S4;
                    leds_nxt  = off_step;
                end else if (leds == 16'hFFFF) begin
                    state_nxt = S6;
                    leds_nxt  = off_step;
                end else leds_nxt = on_step;
            end
            S6: begin
                if (leds == 16'h0000) begin
                    state_nxt = IDLE;
                    leds_nxt  = 16'h0000;
                end else leds_nxt = off_step;
            end
            default: begin
                state_nxt = IDLE;
                leds_nxt  = 16'h0000;
            end
        endcase
    end

    assign bus.LEDs = leds;
endmodule

// File: tb/tb_bound_flasher.sv
// Bench for bound_flasher: lamp-count/leg reference model feeds an expectation
// queue; a monitor pops one entry per rising edge and compares LEDs.
module tb_bound_flasher;
    logic clk, rst;
    bound_flasher_if bus ();

    bound_flasher dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] expq[$];

    // Pattern as legs of lit-lamp counts: each leg walks toward its target.
    int tgt[6] = '{6, 0, 11, 5, 16, 0};
    int mleg = -1;
    int mn   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: LEDs=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic mstep(input bit f, input bit r);
        if (r) begin
            mleg = -1;
            mn   = 0;
        end else if (mleg < 0) begin
            if (f) begin
                mleg = 0;
                mn   = 1;
            end
        end else if (f && (mleg == 2 || mleg == 4) && (mn == 6 || mn == 11)) begin
            mleg = mleg - 1;
            mn   = mn - 1;
        end else if (mn == tgt[mleg]) begin
            if (mleg == 5) mleg = -1;
            else begin
                mleg = mleg + 1;
                mn   = mn + ((tgt[mleg] > mn) ? 1 : -1);
            end
        end else begin
            mn = mn + ((tgt[mleg] > mn) ? 1 : -1);
        end
    endtask

    task automatic cycle(input bit f, input bit r);
        @(negedge clk);
        bus.flick = f;
        rst       = r;
        mstep(f, r);
        expq.push_back(pat(mn));
    endtask

    task automatic go_to(input int l, input int v, input string name);
        int k;
        k = 0;
        while (!(mleg == l && mn == v) && k < 300) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s: leg %0d count %0d not reached, model at %0d/%0d", name, l, v, mleg, mn);
        end
    endtask

    task automatic flick_at(input int l, input int v, input string name);
        go_to(l, v, name);
        cycle(1'b1, 1'b0);
    endtask

    task automatic start_and_idle(input bit kick);
        if (kick) cycle(1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        go_to(-1, 0, name);
        cycle(1'b0, 1'b0);
    endtask

    // Monitor: one output per rising edge, compared against the queue head.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("seq", bus.LEDs, e);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus.flick = 1'b0;
        repeat (3) cycle(1'b0, 1'b1);
        #1 chk("reset", bus.LEDs, 16'h0000);
        repeat (4) cycle(1'b0, 1'b0);

        // nominal pass, then sitting in idle
        cycle(1'b1, 1'b0);
        repeat (64) cycle(1'b0, 1'b0);

        // S3 kickbacks
        cycle(1'b1, 1'b0);
        flick_at(2, 6, "s3_kick_3f");
        flick_at(2, 11, "s3_kick_7ff");
        drain("s3_drain");

        // S5 kickbacks
        cycle(1'b1, 1'b0);
        flick_at(4, 11, "s5_kick_7ff");
        flick_at(4, 6, "s5_kick_3f");
        drain("s5_drain");

        // flicks that must be ignored
        cycle(1'b1, 1'b0);
        flick_at(0, 3, "ign_s1");
        flick_at(0, 6, "ign_s1_top");
        flick_at(1, 3, "ign_s2");
        flick_at(2, 3, "ign_s3");
        flick_at(3, 8, "ign_s4");
        flick_at(4, 8, "ign_s5");
        flick_at(5, 11, "ign_s6_7ff");
        flick_at(5, 6, "ign_s6_3f");
        drain("ign_drain");

        // flick held across the end of the pattern restarts it
        cycle(1'b1, 1'b0);
        go_to(5, 2, "hold_go");
        repeat (6) cycle(1'b1, 1'b0);
        drain("hold_drain");

        // async reset in the middle of S3
        cycle(1'b1, 1'b0);
        go_to(2, 8, "rst_s3_go");
        cycle(1'b0, 1'b1);
        #1 chk("async_rst", bus.LEDs, 16'h0000);
        cycle(1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);

        // reset together with flick in S6, then restart on release
        cycle(1'b1, 1'b0);
        go_to(5, 9, "rst_s6_go");
        cycle(1'b1, 1'b1);
        #1 chk("rst_flick_s6", bus.LEDs, 16'h0000);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        drain("rst_s6_drain");

`ifdef FLICK_LATCH_EN
        // short pulse between edges is held until the next edge
        @(negedge clk);
        bus.flick = 1'b0;
        rst       = 1'b0;
        mstep(1'b1, 1'b0);
        expq.push_back(pat(mn));
        #1 bus.flick = 1'b1;
        #3 bus.flick = 1'b0;
        drain("latch_drain");
`endif

        // randomized flick traffic with rare resets
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        cycle(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_queue: %0d entries left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
